// File: rtl/dsp_seq_pkg.sv
// Shared types and constants for the DSP48A1-style MAC sequencer.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
//
// Contents: FSM state enum, OPMODE words, datapath widths and a saturating
// counter helper used for the per-job pair count.
package dsp_seq_pkg;

  localparam int A_W   = 18;  // operand width on the slice A/B ports
  localparam int P_W   = 48;  // slice P width
  localparam int CNT_W = 16;  // pair counter width
  localparam int OPM_W = 8;   // slice OPMODE width

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  // OPMODE[1:0] selects X (01 = multiplier M), OPMODE[3:2] selects Z (10 = P).
  localparam logic [OPM_W-1:0] OPM_NONE  = 8'h00;  // idle: X=0, Z=0
  localparam logic [OPM_W-1:0] OPM_FIRST = 8'h01;  // X=M, Z=0 (starts a job)
  localparam logic [OPM_W-1:0] OPM_ACC   = 8'h09;  // X=M, Z=P
  localparam logic [OPM_W-1:0] OPM_HOLD  = 8'h08;  // X=0, Z=P (bubble)

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/dsp_seq_dly.sv
// Fixed-depth shift register with synchronous active-low clear.
// Latency: DEPTH cycles from i_d to o_q (DEPTH >= 1).
// Backpressure: none; shifts every cycle.
//
// Ports:
//   clk     in  clock
//   i_clr_n in  synchronous clear, active low (all stages to zero)
//   i_d     in  W-bit data entering the first stage
//   o_q     out W-bit data leaving the last stage
module dsp_seq_dly #(
  parameter int W     = 8,
  parameter int DEPTH = 1
) (
  input  logic         clk,
  input  logic         i_clr_n,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);

  logic [W-1:0] r_sr [DEPTH];

  always_ff @(posedge clk) begin
    if (!i_clr_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_sr[i] <= '0;
      end
    end else begin
      r_sr[0] <= i_d;
      for (int i = 1; i < DEPTH; i++) begin
        r_sr[i] <= r_sr[i-1];
      end
    end
  end

  assign o_q = r_sr[DEPTH-1];

endmodule

// File: rtl/dsp_mac_seq.sv
// Sequencer driving a DSP48A1-style slice as a multiply-accumulate engine.
// Latency: result valid PIPE_LAT+1 cycles after the last pair handshake.
// Backpressure: s_ready drops from the last pair until the result transfers.
//
// Optional feature macro: SEQ_TIMEOUT_EN (adds m_timeout and an idle-input
// timeout that forces a job to finish; without it ACCUM waits indefinitely).
//
// Ports:
//   clk, RSTN                  clock, synchronous active-low reset
//   s_valid/s_ready            operand stream handshake
//   s_a, s_b, s_last           signed 18-bit operands, end-of-job marker
//   dsp_a, dsp_b, dsp_opmode   registered drive to the slice
//   dsp_p                      slice P output (passed through untouched)
//   m_valid/m_ready            result handshake
//   m_data, m_count            accumulated result, pairs in job (saturating)
//   m_timeout                  result was forced by the timeout (macro only)
//   busy                       any state other than IDLE
module dsp_mac_seq
  import dsp_seq_pkg::*;
#(
  parameter int PIPE_LAT = 4,
  parameter int OPM_DLY  = 2,
  parameter int TIMEOUT  = 16
) (
  input  logic                  clk,
  input  logic                  RSTN,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic signed [A_W-1:0] s_a,
  input  logic signed [A_W-1:0] s_b,
  input  logic                  s_last,
  output logic signed [A_W-1:0] dsp_a,
  output logic signed [A_W-1:0] dsp_b,
  output logic [OPM_W-1:0]      dsp_opmode,
  input  logic [P_W-1:0]        dsp_p,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [P_W-1:0]        m_data,
  output logic [CNT_W-1:0]      m_count,
`ifdef SEQ_TIMEOUT_EN
  output logic                  m_timeout,
`endif
  output logic                  busy
);

  // Reject configurations the drain counter and OPMODE delay cannot honour.
  if (PIPE_LAT < 2 || PIPE_LAT > 8 || OPM_DLY < 0 || OPM_DLY >= PIPE_LAT ||
      TIMEOUT < 1) begin : g_bad_cfg
    $error("dsp_mac_seq: illegal PIPE_LAT/OPM_DLY/TIMEOUT combination");
  end

  // Drain counter holds values 0..PIPE_LAT (PIPE_LAT <= 8).
  localparam int                DCNT_W     = 4;
  localparam logic [DCNT_W-1:0] DRAIN_LOAD = DCNT_W'(PIPE_LAT);

`ifdef SEQ_TIMEOUT_EN
  localparam int              TO_W    = $clog2(TIMEOUT + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);
`endif

  state_t                r_state;
  logic                  r_s_ready;
  logic signed [A_W-1:0] r_dsp_a;
  logic signed [A_W-1:0] r_dsp_b;
  logic [CNT_W-1:0]      r_cnt;
  logic [DCNT_W-1:0]     r_drain_cnt;
  logic                  r_m_valid;
  logic [P_W-1:0]        r_m_data;
  logic [CNT_W-1:0]      r_m_count;
`ifdef SEQ_TIMEOUT_EN
  logic [TO_W-1:0]       r_idle_cnt;
  logic                  r_forced;
  logic                  r_m_timeout;
`endif

  logic                  w_hs;
  logic [OPM_W-1:0]      w_opm_sched;

  // s_ready is registered, so a handshake is simply valid against it.
  assign w_hs = s_valid & r_s_ready;

  // OPMODE word belonging to the operands being issued at this clock edge.
  // It enters a delay line one stage longer than OPM_DLY because the operand
  // registers themselves add one cycle; both then leave aligned as required.
  always_comb begin
    w_opm_sched = OPM_NONE;
    case (r_state)
      IDLE:    w_opm_sched = w_hs ? OPM_FIRST : OPM_NONE;
      ACCUM:   w_opm_sched = w_hs ? OPM_ACC : OPM_HOLD;
      DRAIN:   w_opm_sched = OPM_HOLD;  // keep P while the pipe empties
      default: w_opm_sched = OPM_NONE;
    endcase
  end

  dsp_seq_dly #(
    .W     (OPM_W),
    .DEPTH (OPM_DLY + 1)
  ) u_opm_dly (
    .clk     (clk),
    .i_clr_n (RSTN),
    .i_d     (w_opm_sched),
    .o_q     (dsp_opmode)
  );

  always_ff @(posedge clk) begin
    if (!RSTN) begin
      r_state     <= IDLE;
      r_s_ready   <= 1'b0;
      r_dsp_a     <= '0;
      r_dsp_b     <= '0;
      r_cnt       <= '0;
      r_drain_cnt <= '0;
      r_m_valid   <= 1'b0;
      r_m_data    <= '0;
      r_m_count   <= '0;
`ifdef SEQ_TIMEOUT_EN
      r_idle_cnt  <= '0;
      r_forced    <= 1'b0;
      r_m_timeout <= 1'b0;
`endif
    end else begin
      // Bubble on the slice inputs unless a pair is issued this cycle.
      r_dsp_a <= '0;
      r_dsp_b <= '0;

      case (r_state)
        IDLE: begin
          r_s_ready <= 1'b1;
          if (w_hs) begin
            r_dsp_a <= s_a;
            r_dsp_b <= s_b;
            r_cnt   <= CNT_W'(1);
`ifdef SEQ_TIMEOUT_EN
            r_idle_cnt <= '0;
            r_forced   <= 1'b0;
`endif
            if (s_last) begin
              r_state     <= DRAIN;
              r_s_ready   <= 1'b0;
              r_drain_cnt <= DRAIN_LOAD;
            end else begin
              r_state <= ACCUM;
            end
          end
        end

        ACCUM: begin
          r_s_ready <= 1'b1;
          if (w_hs) begin
            r_dsp_a <= s_a;
            r_dsp_b <= s_b;
            r_cnt   <= sat_inc(r_cnt);
`ifdef SEQ_TIMEOUT_EN
            r_idle_cnt <= '0;
`endif
            if (s_last) begin
              r_state     <= DRAIN;
              r_s_ready   <= 1'b0;
              r_drain_cnt <= DRAIN_LOAD;
            end
          end else begin
`ifdef SEQ_TIMEOUT_EN
            // Starved for TIMEOUT cycles: finish the job as if s_last came.
            if (r_idle_cnt == TO_LAST) begin
              r_state     <= DRAIN;
              r_s_ready   <= 1'b0;
              r_drain_cnt <= DRAIN_LOAD;
              r_forced    <= 1'b1;
            end else begin
              r_idle_cnt <= r_idle_cnt + 1'b1;
            end
`endif
          end
        end

        DRAIN: begin
          r_s_ready <= 1'b0;
          // Zero means dsp_p now carries the last issued pair's contribution.
          if (r_drain_cnt == '0) begin
            r_m_data  <= dsp_p;
            r_m_count <= r_cnt;
            r_m_valid <= 1'b1;
            r_state   <= DONE;
`ifdef SEQ_TIMEOUT_EN
            r_m_timeout <= r_forced;
`endif
          end else begin
            r_drain_cnt <= r_drain_cnt - 1'b1;
          end
        end

        DONE: begin
          r_s_ready <= 1'b0;
          if (m_ready) begin
            r_m_valid <= 1'b0;
            r_state   <= IDLE;
            r_s_ready <= 1'b1;  // next pair lands the cycle after transfer
`ifdef SEQ_TIMEOUT_EN
            r_m_timeout <= 1'b0;
`endif
          end
        end

        default: begin
          r_state   <= IDLE;
          r_s_ready <= 1'b0;
        end
      endcase
    end
  end

  assign s_ready = r_s_ready;
  assign dsp_a   = r_dsp_a;
  assign dsp_b   = r_dsp_b;
  assign m_valid = r_m_valid;
  assign m_data  = r_m_data;
  assign m_count = r_m_count;
  assign busy    = (r_state != IDLE);
`ifdef SEQ_TIMEOUT_EN
  assign m_timeout = r_m_timeout;
`endif

endmodule

// File: tb/tb_dsp_mac_seq.sv
// Self-checking bench for dsp_mac_seq with a behavioural DSP slice model.
// Latency: expects results PIPE_LAT+1 cycles after the last pair.
// Backpressure: exercises m_ready held low and s_valid held during DONE.
module tb_dsp_mac_seq;

  localparam int PIPE_LAT = 4;
  localparam int OPM_DLY  = 2;
  localparam int TIMEOUT  = 16;

  localparam logic [7:0] W_NONE  = 8'h00;
  localparam logic [7:0] W_FIRST = 8'h01;
  localparam logic [7:0] W_ACC   = 8'h09;
  localparam logic [7:0] W_HOLD  = 8'h08;

  logic               clk = 1'b0;
  logic               RSTN;
  logic               s_valid;
  logic               s_ready;
  logic signed [17:0] s_a;
  logic signed [17:0] s_b;
  logic               s_last;
  logic signed [17:0] dsp_a;
  logic signed [17:0] dsp_b;
  logic [7:0]         dsp_opmode;
  logic [47:0]        dsp_p;
  logic               m_valid;
  logic               m_ready;
  logic [47:0]        m_data;
  logic [15:0]        m_count;
  logic               busy;
`ifdef SEQ_TIMEOUT_EN
  logic               m_timeout;
  logic               g_exp_to = 1'b0;
`endif

  int n_cmp = 0;
  int n_err = 0;
  int tcyc  = 0;

  logic [7:0]         opm_log [int];  // dsp_opmode seen after each edge
  logic [7:0]         exp_opm [int];  // expected word keyed by issue edge
  logic signed [17:0] pa [0:63];
  logic signed [17:0] pb [0:63];
  int                 pg [0:63];      // idle cycles before each pair

  always #5 clk = ~clk;

  dsp_mac_seq #(
    .PIPE_LAT (PIPE_LAT),
    .OPM_DLY  (OPM_DLY),
    .TIMEOUT  (TIMEOUT)
  ) u_dut (
    .clk        (clk),
    .RSTN       (RSTN),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .s_a        (s_a),
    .s_b        (s_b),
    .s_last     (s_last),
    .dsp_a      (dsp_a),
    .dsp_b      (dsp_b),
    .dsp_opmode (dsp_opmode),
    .dsp_p      (dsp_p),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_data     (m_data),
    .m_count    (m_count),
`ifdef SEQ_TIMEOUT_EN
    .m_timeout  (m_timeout),
`endif
    .busy       (busy)
  );

  // Slice model: the OPMODE word arriving now applies to operands presented
  // OPM_DLY cycles earlier; the new P shows up PIPE_LAT cycles after issue.
  logic signed [17:0] ha [0:15];
  logic signed [17:0] hb [0:15];
  logic signed [47:0] pp [0:15];
  logic signed [47:0] acc = '0;
  logic signed [47:0] mul;

  initial begin
    dsp_p = '0;
    for (int i = 0; i < 16; i++) begin
      ha[i] = '0;
      hb[i] = '0;
      pp[i] = '0;
    end
  end

  always @(posedge clk) begin
    for (int i = 15; i > 0; i--) begin
      ha[i] = ha[i-1];
      hb[i] = hb[i-1];
      pp[i] = pp[i-1];
    end
    ha[0] = dsp_a;
    hb[0] = dsp_b;
    mul = ha[OPM_DLY] * hb[OPM_DLY];
    acc = ((dsp_opmode[1:0] == 2'b01) ? mul : 48'sd0) +
          ((dsp_opmode[3:2] == 2'b10) ? acc : 48'sd0);
    pp[0] = acc;
    dsp_p <= pp[PIPE_LAT - OPM_DLY - 1];
  end

  task automatic step();
    @(posedge clk);
    #1;
    tcyc++;
    opm_log[tcyc] = dsp_opmode;
  endtask

  // Drive pairs pa/pb with pg gaps; records expected OPMODE per issue edge.
  task automatic drive_job(input int n, input bit with_last, output int last_edge);
    for (int i = 0; i < n; i++) begin
      int w;
      for (int g = 0; g < pg[i]; g++) begin
        s_valid = 1'b0;
        s_last  = 1'b0;
        if (i > 0) exp_opm[tcyc+1] = W_HOLD;
        step();
      end
      s_valid = 1'b1;
      s_a     = pa[i];
      s_b     = pb[i];
      s_last  = with_last && (i == n - 1);
      w = 0;
      while (s_ready !== 1'b1 && w < 50) begin
        step();
        w++;
      end
      n_cmp++;
      if (s_ready !== 1'b1) begin
        n_err++;
        $display("FAIL accept_wait: s_ready=%b after %0d cycles, required 1", s_ready, w);
      end
      exp_opm[tcyc+1] = (i == 0) ? W_FIRST : W_ACC;
      step();
    end
    s_valid   = 1'b0;
    s_last    = 1'b0;
    last_edge = tcyc;
  endtask

  // Wait for the result, check it, hold m_ready low 'hold' cycles (0 means
  // ready already high before m_valid), then complete the transfer.
  task automatic wait_result(input int last_edge, input int exp_lat,
                             input logic [47:0] exp_d, input logic [15:0] exp_c,
                             input int hold);
    int w = 0;
    m_ready = (hold == 0);
    while (m_valid !== 1'b1 && w < 200) begin
      step();
      w++;
    end
    n_cmp++;
    if (m_valid !== 1'b1) begin
      n_err++;
      $display("FAIL result_wait: m_valid=%b after %0d cycles, required 1", m_valid, w);
      m_ready = 1'b0;
      return;
    end
    if (exp_lat >= 0) begin
      n_cmp++;
      if (tcyc - last_edge != exp_lat) begin
        n_err++;
        $display("FAIL latency: got %0d cycles, required %0d", tcyc - last_edge, exp_lat);
      end
    end
    n_cmp++;
    if (m_data !== exp_d) begin
      n_err++;
      $display("FAIL m_data: got %h, required %h", m_data, exp_d);
    end
    n_cmp++;
    if (m_count !== exp_c) begin
      n_err++;
      $display("FAIL m_count: got %0d, required %0d", m_count, exp_c);
    end
    n_cmp++;
    if (s_ready !== 1'b0 || busy !== 1'b1) begin
      n_err++;
      $display("FAIL done_flags: s_ready=%b busy=%b, required 0/1", s_ready, busy);
    end
`ifdef SEQ_TIMEOUT_EN
    n_cmp++;
    if (m_timeout !== g_exp_to) begin
      n_err++;
      $display("FAIL m_timeout: got %b, required %b", m_timeout, g_exp_to);
    end
`endif
    for (int i = 0; i < hold; i++) begin
      step();
      n_cmp++;
      if (m_valid !== 1'b1 || m_data !== exp_d || m_count !== exp_c || s_ready !== 1'b0) begin
        n_err++;
        $display("FAIL hold: m_valid=%b m_data=%h m_count=%0d s_ready=%b, required 1/%h/%0d/0",
                 m_valid, m_data, m_count, s_ready, exp_d, exp_c);
      end
    end
    m_ready = 1'b1;
    step();
    m_ready = 1'b0;
    n_cmp++;
    if (m_valid !== 1'b0 || s_ready !== 1'b1 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL transfer: m_valid=%b s_ready=%b busy=%b, required 0/1/0",
               m_valid, s_ready, busy);
    end
`ifdef SEQ_TIMEOUT_EN
    n_cmp++;
    if (m_timeout !== 1'b0) begin
      n_err++;
      $display("FAIL m_timeout_clear: got %b, required 0", m_timeout);
    end
`endif
  endtask

  task automatic check_opm(input string name);
    foreach (exp_opm[k]) begin
      n_cmp++;
      if (!opm_log.exists(k + OPM_DLY)) begin
        n_err++;
        $display("FAIL opmode_%s: no sample at edge %0d, required %h", name, k + OPM_DLY, exp_opm[k]);
      end else if (opm_log[k + OPM_DLY] !== exp_opm[k]) begin
        n_err++;
        $display("FAIL opmode_%s: edge %0d got %h, required %h",
                 name, k + OPM_DLY, opm_log[k + OPM_DLY], exp_opm[k]);
      end
    end
    exp_opm.delete();
  endtask

  function automatic logic [47:0] ref_sum(input int n);
    logic signed [47:0] s;
    logic signed [47:0] p;
    s = '0;
    for (int i = 0; i < n; i++) begin
      p = pa[i] * pb[i];
      s = s + p;
    end
    return s;
  endfunction

  task automatic check_reset_outputs(input string name);
    n_cmp++;
    if (dsp_a !== 18'sd0 || dsp_b !== 18'sd0 || dsp_opmode !== W_NONE) begin
      n_err++;
      $display("FAIL %s_dsp: a=%h b=%h opmode=%h, required 0/0/00", name, dsp_a, dsp_b, dsp_opmode);
    end
    n_cmp++;
    if (m_valid !== 1'b0 || m_data !== 48'd0 || m_count !== 16'd0) begin
      n_err++;
      $display("FAIL %s_result: m_valid=%b m_data=%h m_count=%0d, required 0/0/0",
               name, m_valid, m_data, m_count);
    end
    n_cmp++;
    if (s_ready !== 1'b0 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL %s_ctrl: s_ready=%b busy=%b, required 0/0", name, s_ready, busy);
    end
  endtask

  task automatic test_reset();
    RSTN = 1'b0;
    step();
    step();
    check_reset_outputs("reset");
    RSTN = 1'b1;
    step();
    n_cmp++;
    if (s_ready !== 1'b1) begin
      n_err++;
      $display("FAIL reset_release: s_ready=%b, required 1", s_ready);
    end
  endtask

  task automatic test_single();
    int le;
    pa[0] = 18'sd3;
    pb[0] = -18'sd5;
    pg[0] = 0;
    drive_job(1, 1'b1, le);
    wait_result(le, PIPE_LAT + 1, 48'hFFFF_FFFF_FFF1, 16'd1, 0);
    check_opm("single");
  endtask

  task automatic test_four(input bit with_gaps);
    int le;
    for (int i = 0; i < 4; i++) begin
      pa[i] = 18'(2 * i + 1);
      pb[i] = 18'(2 * i + 2);
      pg[i] = 0;
    end
    if (with_gaps) pg[2] = 2;
    drive_job(4, 1'b1, le);
    wait_result(le, PIPE_LAT + 1, 48'd100, 16'd4, 1);
    check_opm(with_gaps ? "gaps" : "four");
  endtask

  // Next job's first pair is presented while the previous result waits.
  task automatic test_back_to_back();
    int le;
    logic [47:0] e1;
    for (int i = 0; i < 3; i++) begin
      pa[i] = 18'($urandom);
      pb[i] = 18'($urandom);
      pg[i] = 0;
    end
    drive_job(3, 1'b1, le);
    e1 = ref_sum(3);
    pa[0] = -18'sd7;
    pb[0] = 18'sd9;
    pa[1] = 18'sd11;
    pb[1] = 18'sd13;
    pg[1] = 1;
    s_valid = 1'b1;
    s_a     = pa[0];
    s_b     = pb[0];
    s_last  = 1'b0;
    wait_result(le, PIPE_LAT + 1, e1, 16'd3, 5);
    check_opm("b2b_first");
    drive_job(2, 1'b1, le);
    wait_result(le, PIPE_LAT + 1, 48'd80, 16'd2, 2);
    check_opm("b2b_second");
  endtask

  task automatic test_reset_mid();
    int le;
    bit saw;
    pa[0] = 18'sd5;
    pb[0] = 18'sd6;
    pa[1] = -18'sd4;
    pb[1] = 18'sd3;
    pg[0] = 0;
    pg[1] = 0;
    drive_job(2, 1'b0, le);
    RSTN = 1'b0;
    step();
    check_reset_outputs("reset_mid");
    RSTN = 1'b1;
    exp_opm.delete();
    saw = 1'b0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (m_valid === 1'b1) saw = 1'b1;
    end
    n_cmp++;
    if (saw !== 1'b0) begin
      n_err++;
      $display("FAIL reset_mid_no_result: m_valid seen=%b, required 0", saw);
    end
    pa[0] = 18'sd2;
    pb[0] = 18'sd2;
    drive_job(1, 1'b1, le);
    wait_result(le, PIPE_LAT + 1, 48'd4, 16'd1, 0);
    check_opm("after_reset");
  endtask

  task automatic test_timeout();
    int le;
    pa[0] = 18'sd1;
    pb[0] = 18'sd1;
    pa[1] = 18'sd1;
    pb[1] = 18'sd1;
    pg[0] = 0;
    pg[1] = 0;
    drive_job(2, 1'b0, le);
`ifdef SEQ_TIMEOUT_EN
    g_exp_to = 1'b1;
    wait_result(le, -1, 48'd2, 16'd2, 0);
    g_exp_to = 1'b0;
    check_opm("timeout");
`else
    begin
      bit saw = 1'b0;
      for (int i = 0; i < 3 * TIMEOUT; i++) begin
        step();
        if (m_valid === 1'b1) saw = 1'b1;
      end
      n_cmp++;
      if (saw !== 1'b0 || busy !== 1'b1 || s_ready !== 1'b1) begin
        n_err++;
        $display("FAIL no_timeout: m_valid seen=%b busy=%b s_ready=%b, required 0/1/1",
                 saw, busy, s_ready);
      end
      check_opm("stalled");
      RSTN = 1'b0;
      step();
      RSTN = 1'b1;
      step();
    end
`endif
  endtask

  task automatic test_random();
    int le;
    int n;
    for (int j = 0; j < 8; j++) begin
      n = $urandom_range(1, 7);
      for (int i = 0; i < n; i++) begin
        pa[i] = 18'($urandom);
        pb[i] = 18'($urandom);
        pg[i] = $urandom_range(0, 2);
      end
      if (j == 0) begin
        pa[0] = -18'sd131072;
        pb[0] = -18'sd131072;
      end
      drive_job(n, 1'b1, le);
      wait_result(le, PIPE_LAT + 1, ref_sum(n), 16'(n), $urandom_range(0, 3));
      check_opm("random");
    end
  endtask

  initial begin
    RSTN    = 1'b0;
    s_valid = 1'b0;
    s_a     = '0;
    s_b     = '0;
    s_last  = 1'b0;
    m_ready = 1'b0;
    test_reset();
    test_single();
    test_four(1'b0);
    test_four(1'b1);
    test_back_to_back();
    test_reset_mid();
    test_timeout();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
